// File: rtl/cipher_arbiter.sv
// ---------------------------------------------------------------------------
// cipher_arbiter
//
// Two-requester front end for a single cipher core. Requests are sampled only
// while idle; a round-robin pointer breaks ties. The granted plaintext block
// is registered onto core_din, the core is kicked with a one-cycle start
// pulse, and the core result is registered onto the shared dout bus when the
// core signals completion.
//
// Ports
//   CK          clock, rising edge
//   RN          asynchronous active-low reset
//   req0/req1   level requests
//   din0/din1   plaintext blocks, valid while the matching req is high
//   ack0/ack1   one-cycle pulse: block taken (START cycle)
//   done0/done1 one-cycle pulse: dout holds this requester's result
//   dout        registered result block
//   busy        high whenever not idle
//   core_start  one-cycle start pulse to the core
//   core_din    registered block presented to the core
//   core_ready  one-cycle completion pulse from the core
//   core_dout   core result, valid with core_ready
// ---------------------------------------------------------------------------
module cipher_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] din0,
  input  logic [N-1:0] din1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] dout,
  output logic         busy,
  output logic         core_start,
  output logic [N-1:0] core_din,
  input  logic         core_ready,
  input  logic [N-1:0] core_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic         grant_q, grant_d;   // requester currently being served
  logic         last_q, last_d;     // requester served most recently
  logic [N-1:0] core_din_q, core_din_d;
  logic [N-1:0] dout_q, dout_d;

  logic         any_req;
  logic         pick;

  // Arbitration: on a tie the requester not served last wins; a lone
  // request wins regardless of the pointer.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 & req1) ? ~last_q : req1;
  end

  // Next-state and datapath updates. core_ready is only looked at in RUN,
  // so stray completion pulses elsewhere leave state and dout untouched.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    core_din_d = core_din_q;
    dout_d     = dout_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = START;
          grant_d    = pick;
          last_d     = pick;
          core_din_d = pick ? din1 : din0;
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        if (core_ready) begin
          dout_d  = core_dout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      core_din_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      core_din_q <= core_din_d;
      dout_q     <= dout_d;
    end
  end

  // All handshake outputs decode registered state only.
  always_comb begin
    busy       = (state_q != IDLE);
    core_start = (state_q == START);
    ack0       = (state_q == START) & ~grant_q;
    ack1       = (state_q == START) &  grant_q;
    done0      = (state_q == DONE)  & ~grant_q;
    done1      = (state_q == DONE)  &  grant_q;
    dout       = dout_q;
    core_din   = core_din_q;
  end

endmodule

// File: tb/tb_cipher_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cipher_arbiter
//
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a transaction-level model that tracks cycle numbers of the current
// grant, start and done events; a small core model answers each grant with
// ~din after K cycles and can inject stray core_ready pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cipher_arbiter;

  localparam int unsigned N = 64;

  logic         CK, RN, req0, req1, core_ready;
  logic [N-1:0] din0, din1, core_dout, dout, core_din;
  logic         ack0, ack1, done0, done1, busy, core_start;

  cipher_arbiter #(.N(N)) dut (
    .CK         (CK),
    .RN         (RN),
    .req0       (req0),
    .req1       (req1),
    .din0       (din0),
    .din1       (din1),
    .ack0       (ack0),
    .ack1       (ack1),
    .done0      (done0),
    .done1      (done1),
    .dout       (dout),
    .busy       (busy),
    .core_start (core_start),
    .core_din   (core_din),
    .core_ready (core_ready),
    .core_dout  (core_dout)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // transaction-level reference model
  bit           m_active;
  bit           m_grant;
  bit           m_last;
  int           m_start;
  int           m_done;
  logic [N-1:0] m_dout, m_core_din;

  // core model / stimulus knobs
  int           ready_at;
  int           cur_k;
  bit           force_ready;
  bit           spur_start;
  logic [N-1:0] spur_val;

  // observations of the DUT
  int n_cs, n_ack0, n_ack1, n_done0, n_done1;
  int cs_cyc[$];
  int ack_q[$];
  int last_done_cyc;

  function automatic logic [N-1:0] ext(input logic b);
    return {{(N-1){1'b0}}, b};
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_grant    = 1'b0;
    m_last     = 1'b1;
    m_start    = -100;
    m_done     = -1;
    m_dout     = '0;
    m_core_din = '0;
  endtask

  task automatic zero_counts();
    n_cs = 0; n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0;
  endtask

  task automatic check_outputs();
    bit cs_e;
    bit dn_e;
    cs_e = m_active && (cyc == m_start);
    dn_e = m_active && (cyc == m_done);
    chk("busy",       ext(busy),       ext(m_active));
    chk("core_start", ext(core_start), ext(cs_e));
    chk("ack0",       ext(ack0),       ext(cs_e && !m_grant));
    chk("ack1",       ext(ack1),       ext(cs_e &&  m_grant));
    chk("done0",      ext(done0),      ext(dn_e && !m_grant));
    chk("done1",      ext(done1),      ext(dn_e &&  m_grant));
    chk("dout",       dout,            m_dout);
    chk("core_din",   core_din,        m_core_din);
    chk("ack_excl",   ext(ack0 & ack1),   '0);
    chk("done_excl",  ext(done0 & done1), '0);
  endtask

  task automatic observe();
    if (core_start === 1'b1) begin n_cs++; cs_cyc.push_back(cyc); end
    if (ack0 === 1'b1)  begin n_ack0++; ack_q.push_back(0); end
    if (ack1 === 1'b1)  begin n_ack1++; ack_q.push_back(1); end
    if (done0 === 1'b1) begin n_done0++; last_done_cyc = cyc; end
    if (done1 === 1'b1) begin n_done1++; last_done_cyc = cyc; end
  endtask

  // One clock: sample inputs, advance the model across the edge, check at
  // the falling edge, then drive the core inputs for the new cycle.
  task automatic tick();
    bit           r0, r1, rn, crdy, g;
    logic [N-1:0] d0, d1, cd;
    r0 = req0; r1 = req1; rn = RN; crdy = core_ready;
    d0 = din0; d1 = din1; cd = core_dout;
    @(posedge CK);
    cyc++;
    if (rn) begin
      if (!m_active) begin
        if (r0 || r1) begin
          g          = (r0 && r1) ? !m_last : r1;
          m_active   = 1'b1;
          m_grant    = g;
          m_last     = g;
          m_start    = cyc;
          m_done     = -1;
          m_core_din = g ? d1 : d0;
          ready_at   = cyc + cur_k;
        end
      end else if (m_done < 0) begin
        if (crdy && (cyc - 1 > m_start)) begin
          m_dout = cd;
          m_done = cyc;
        end
      end else if (cyc - 1 == m_done) begin
        m_active = 1'b0;
      end
    end
    @(negedge CK);
    check_outputs();
    observe();
    core_ready = 1'b0;
    core_dout  = '0;
    if (force_ready || (spur_start && m_active && cyc == m_start)) begin
      core_ready = 1'b1;
      core_dout  = spur_val;
    end
    if (cyc == ready_at) begin
      core_ready = 1'b1;
      core_dout  = ~m_core_din;
    end
  endtask

  task automatic reset_pulse(input int edges);
    RN = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (edges) tick();
    RN = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", ext(busy), '0);
  endtask

  initial begin
    int           n;
    logic [N-1:0] saved;
    RN = 1'b1; req0 = 1'b0; req1 = 1'b0;
    din0 = '0; din1 = '0; core_ready = 1'b0; core_dout = '0;
    cur_k = 1; force_ready = 1'b0; spur_start = 1'b0;
    spur_val = 64'hDEAD; ready_at = -100; last_done_cyc = 0;
    model_reset();
    zero_counts();

    #2;
    reset_pulse(2);

    // stray core_ready while idle
    force_ready = 1'b1;
    spur_val    = 64'hDEAD;
    repeat (3) tick();
    chk("spur_idle_dout", dout, '0);
    force_ready = 1'b0;
    tick();

    // single request, K = 33, plus a stray ready in START
    cs_cyc.delete();
    req0 = 1'b1;
    din0 = 64'h0123456789ABCDEF;
    cur_k = 33;
    spur_start = 1'b1;
    tick();
    req0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin tick(); n++; end
    chk("k33_cs_count", N'(cs_cyc.size()), N'(1));
    if (cs_cyc.size() > 0)
      chk("k33_latency", N'(last_done_cyc - cs_cyc[0]), N'(34));
    chk("k33_dout", dout, 64'hFEDCBA9876543210);
    spur_start = 1'b0;
    tick();
    chk("k33_busy_after", ext(busy), '0);

    // tie at reset release: grants alternate 0,1,0,1
    req0 = 1'b1; req1 = 1'b1;
    reset_pulse(2);
    ack_q.delete();
    n = 0;
    while (ack_q.size() < 4 && n < 300) begin
      cur_k = $urandom_range(1, 5);
      din0  = {$urandom(), $urandom()};
      din1  = {$urandom(), $urandom()};
      tick();
      n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(20);
    chk("tie_ack_count", N'(ack_q.size()), N'(4));
    for (int i = 0; i < 4; i++)
      if (i < ack_q.size()) chk("tie_order", N'(ack_q[i]), N'(i % 2));

    // late request pulsed during RUN is ignored
    zero_counts();
    req0 = 1'b1; din0 = {$urandom(), $urandom()}; cur_k = 20;
    tick();
    req0 = 1'b0;
    repeat (5) tick();
    req1 = 1'b1; din1 = {$urandom(), $urandom()};
    repeat (3) tick();
    req1 = 1'b0;
    wait_idle(40);
    chk("late_cs",    N'(n_cs),    N'(1));
    chk("late_ack1",  N'(n_ack1),  N'(0));
    chk("late_done1", N'(n_done1), N'(0));
    chk("late_done0", N'(n_done0), N'(1));

    // reset ten cycles into RUN; the core answer arrives afterwards
    req0 = 1'b1; din0 = {$urandom(), $urandom()}; cur_k = 40;
    tick();
    req0 = 1'b0;
    repeat (11) tick();
    reset_pulse(1);
    zero_counts();
    n = 0;
    while (cyc <= ready_at + 1 && n < 60) begin tick(); n++; end
    chk("abort_done0", N'(n_done0), N'(0));
    chk("abort_done1", N'(n_done1), N'(0));
    saved = {$urandom(), $urandom()};
    req1 = 1'b1; din1 = saved; cur_k = 3;
    tick();
    req1 = 1'b0;
    wait_idle(20);
    chk("after_abort_done1", N'(n_done1), N'(1));
    chk("after_abort_done0", N'(n_done0), N'(0));
    chk("after_abort_dout",  dout, ~saved);

    // back-to-back with K = 1: start-to-start period of 4
    cs_cyc.delete();
    req1 = 1'b1; cur_k = 1;
    n = 0;
    while (cs_cyc.size() < 3 && n < 40) begin tick(); n++; end
    req1 = 1'b0;
    wait_idle(10);
    chk("b2b_starts", N'(cs_cyc.size()), N'(3));
    for (int i = 1; i < 3; i++)
      if (i < cs_cyc.size()) chk("b2b_period", N'(cs_cyc[i] - cs_cyc[i-1]), N'(4));

    // randomized traffic with stray ready pulses and occasional resets
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      din0        = {$urandom(), $urandom()};
      din1        = {$urandom(), $urandom()};
      cur_k       = $urandom_range(1, 6);
      force_ready = ($urandom_range(0, 15) == 0);
      spur_val    = {$urandom(), $urandom()};
      if ($urandom_range(0, 199) == 0) reset_pulse(1);
      else tick();
    end
    req0 = 1'b0; req1 = 1'b0; force_ready = 1'b0;
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
